// File: rtl/pu_msp430_dac_multi_if.sv
// SPI pins and observable outputs of the multi-channel bench DAC model.
// DAC_LDAC_EN adds the ldac_n load strobe pin.
interface pu_msp430_dac_multi_if #(
    parameter int NCH = 4,
    parameter int DW  = 12
);
    logic              din;
    logic              sclk;
    logic              sync_n;
`ifdef DAC_LDAC_EN
    logic              ldac_n;
`endif
    logic [NCH*DW-1:0] vout;
    logic [NCH-1:0]    pd;
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;
    logic              dbg_shift;

    // No handshake: the SPI master drives pins freely and the DAC oversamples
    // them; the outputs are plain levels that are valid every mclk cycle.
`ifdef DAC_LDAC_EN
    modport master (output din, sclk, sync_n, ldac_n,
                    input  vout, pd, frame_cnt, err_cnt, dbg_shift);
    modport slave  (input  din, sclk, sync_n, ldac_n,
                    output vout, pd, frame_cnt, err_cnt, dbg_shift);
`else
    modport master (output din, sclk, sync_n,
                    input  vout, pd, frame_cnt, err_cnt, dbg_shift);
    modport slave  (input  din, sclk, sync_n,
                    output vout, pd, frame_cnt, err_cnt, dbg_shift);
`endif
endinterface

// File: rtl/pu_msp430_dac_multi.sv
// Multi-channel double-buffered SPI DAC model, SPI pins oversampled in mclk.
// Optional macro DAC_LDAC_EN: ldac_n pin, whose falling edge loads all outputs.
module pu_msp430_dac_multi #(
    parameter int            NCH     = 4,
    parameter int            DW      = 12,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input logic                  mclk,
    input logic                  puc_rst,
    pu_msp430_dac_multi_if.slave dac
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    din_sq, sclk_sq, sync_sq;
    logic          sclk_dq, sync_dq;
    logic          sclk_fall, sync_fall, sync_rise;
    logic [15:0]   shift_q, shift_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    fcnt_q, fcnt_d, ecnt_q, ecnt_d;
    logic [DW-1:0] in_q [NCH];
    logic [DW-1:0] in_d [NCH];
    logic [DW-1:0] out_q [NCH];
    logic [DW-1:0] out_d [NCH];
    logic [NCH-1:0] pd_q, pd_d;
    logic [1:0]    f_addr, f_cmd;
    logic [DW-1:0] f_data;
    logic          frame_ok, copy_all;
    logic [NCH*DW-1:0] vout_w;

    // Stage [1] is the synchronised level; the *_dq stage gives the edge.
    assign sclk_fall = ~sclk_sq[1] & sclk_dq;
    assign sync_fall = ~sync_sq[1] & sync_dq;
    assign sync_rise =  sync_sq[1] & ~sync_dq;

    assign f_addr = shift_q[15:14];
    assign f_cmd  = shift_q[13:12];
    assign f_data = shift_q[DW-1:0];

`ifdef DAC_LDAC_EN
    logic [1:0] ldac_sq;
    logic       ldac_dq;
    logic       ldac_fall;
    assign ldac_fall = ~ldac_sq[1] & ldac_dq;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        ecnt_d   = ecnt_q;
        in_d     = in_q;
        out_d    = out_q;
        pd_d     = pd_q;
        frame_ok = 1'b0;
        copy_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A frame-select edge wins over an sclk edge in the same cycle.
                if (sync_rise) begin
                    state_d = IDLE;
                    if (cnt_q == 5'd16) begin
                        frame_ok = 1'b1;
                        if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
                    end else if (ecnt_q != 8'hFF) begin
                        ecnt_d = ecnt_q + 8'd1;
                    end
                end else if (sclk_fall && cnt_q != 5'd16) begin
                    shift_d = {shift_q[14:0], din_sq[1]};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_ok) begin
            for (int k = 0; k < NCH; k++) begin
                if (f_addr == 2'(k)) begin
                    case (f_cmd)
                        2'b00: in_d[k] = f_data;
                        2'b01: begin
                            in_d[k] = f_data;
`ifndef DAC_LDAC_EN
                            out_d[k] = f_data;
                            pd_d[k]  = 1'b0;
`endif
                        end
                        2'b11:   pd_d[k] = 1'b1;
                        default: ;
                    endcase
                end
            end
            copy_all = (f_cmd == 2'b10);
        end
`ifdef DAC_LDAC_EN
        if (ldac_fall) copy_all = 1'b1;
`endif
        // Copy from in_d so a same-cycle frame write reaches the output.
        if (copy_all) begin
            for (int k = 0; k < NCH; k++) out_d[k] = in_d[k];
            pd_d = '0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            din_sq  <= '0;
            sclk_sq <= '1;
            sync_sq <= '1;
            sclk_dq <= 1'b1;
            sync_dq <= 1'b1;
`ifdef DAC_LDAC_EN
            ldac_sq <= '1;
            ldac_dq <= 1'b1;
`endif
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
            pd_q    <= '0;
            for (int k = 0; k < NCH; k++) begin
                in_q[k]  <= RST_VAL;
                out_q[k] <= RST_VAL;
            end
        end else begin
            din_sq  <= {din_sq[0], dac.din};
            sclk_sq <= {sclk_sq[0], dac.sclk};
            sync_sq <= {sync_sq[0], dac.sync_n};
            sclk_dq <= sclk_sq[1];
            sync_dq <= sync_sq[1];
`ifdef DAC_LDAC_EN
            ldac_sq <= {ldac_sq[0], dac.ldac_n};
            ldac_dq <= ldac_sq[1];
`endif
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
            pd_q    <= pd_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        vout_w = '0;
        for (int k = 0; k < NCH; k++) vout_w[k*DW +: DW] = pd_q[k] ? '0 : out_q[k];
    end

    assign dac.vout      = vout_w;
    assign dac.pd        = pd_q;
    assign dac.frame_cnt = fcnt_q;
    assign dac.err_cnt   = ecnt_q;
    assign dac.dbg_shift = (state_q == SHIFT);
endmodule

// File: tb/tb_pu_msp430_dac_multi.sv
// Directed bench for pu_msp430_dac_multi: frame table plus timing corner sequences.
// Expectations follow DAC_LDAC_EN when it is defined.
module tb_pu_msp430_dac_multi;
    localparam int NCH = 4;
    localparam int DW  = 12;
`ifdef DAC_LDAC_EN
    localparam bit LDAC = 1'b1;
`else
    localparam bit LDAC = 1'b0;
`endif

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [47:0] vout_exp;
        logic [47:0] vout_exp_ldac;
        logic [3:0]  pd_exp;
        logic [7:0]  fc_exp;
        logic [7:0]  ec_exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_mis;
    int   exp_fc;
    int   exp_ec;
    logic [47:0] exp_v;
    vec_t vecs [12];

    pu_msp430_dac_multi_if #(.NCH(NCH), .DW(DW)) dac_if ();

    pu_msp430_dac_multi #(.NCH(NCH), .DW(DW), .RST_VAL(12'h000)) dut (
        .mclk    (clk),
        .puc_rst (rst),
        .dac     (dac_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_body(input logic [15:0] w, input int nbits);
        dac_if.sync_n = 1'b0;
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            dac_if.din = (i < 16) ? w[15-i] : 1'b1;
            cyc(2);
            dac_if.sclk = 1'b0;
            cyc(4);
            dac_if.sclk = 1'b1;
            cyc(2);
        end
        cyc(2);
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits);
        frame_body(w, nbits);
        dac_if.sync_n = 1'b1;
        cyc(6);
    endtask

    task automatic chk_all(input string tag, input logic [47:0] v, input logic [3:0] p,
                           input int fc, input int ec);
        chk({tag, ".vout"}, dac_if.vout, v);
        chk({tag, ".pd"}, {44'd0, dac_if.pd}, {44'd0, p});
        chk({tag, ".frame_cnt"}, {40'd0, dac_if.frame_cnt}, 48'(fc));
        chk({tag, ".err_cnt"}, {40'd0, dac_if.err_cnt}, 48'(ec));
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        vecs[0]  = '{16'h5ABC, 16, 48'h000000ABC000, 48'h000000000000, 4'b0000, 8'd1,  8'd0};
        vecs[1]  = '{16'h8123, 16, 48'h000000ABC000, 48'h000000000000, 4'b0000, 8'd2,  8'd0};
        vecs[2]  = '{16'h2000, 16, 48'h000123ABC000, 48'h000123ABC000, 4'b0000, 8'd3,  8'd0};
        vecs[3]  = '{16'hD7FF, 16, 48'h7FF123ABC000, 48'h000123ABC000, 4'b0000, 8'd4,  8'd0};
        vecs[4]  = '{16'hF000, 16, 48'h000123ABC000, 48'h000123ABC000, 4'b1000, 8'd5,  8'd0};
        vecs[5]  = '{16'h2000, 16, 48'h7FF123ABC000, 48'h7FF123ABC000, 4'b0000, 8'd6,  8'd0};
        vecs[6]  = '{16'h0FFF,  9, 48'h7FF123ABC000, 48'h7FF123ABC000, 4'b0000, 8'd6,  8'd1};
        vecs[7]  = '{16'h5456, 20, 48'h7FF123456000, 48'h7FF123ABC000, 4'b0000, 8'd7,  8'd1};
        vecs[8]  = '{16'h0001, 16, 48'h7FF123456000, 48'h7FF123ABC000, 4'b0000, 8'd8,  8'd1};
        vecs[9]  = '{16'h3000, 16, 48'h7FF123456000, 48'h7FF123ABC000, 4'b0001, 8'd9,  8'd1};
        vecs[10] = '{16'hA000, 16, 48'h7FF123456001, 48'h7FF123456001, 4'b0000, 8'd10, 8'd1};
        vecs[11] = '{16'h0000,  0, 48'h7FF123456001, 48'h7FF123456001, 4'b0000, 8'd10, 8'd2};

        rst = 1'b1;
        dac_if.din    = 1'b0;
        dac_if.sclk   = 1'b1;
        dac_if.sync_n = 1'b1;
`ifdef DAC_LDAC_EN
        dac_if.ldac_n = 1'b1;
`endif
        cyc(3);
        rst = 1'b0;
        chk_all("reset", 48'd0, 4'b0000, 0, 0);
        chk("reset.dbg_shift", {47'd0, dac_if.dbg_shift}, 48'd0);
        cyc(4);
        chk_all("post_reset", 48'd0, 4'b0000, 0, 0);
        chk("post_reset.dbg_shift", {47'd0, dac_if.dbg_shift}, 48'd0);

        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].frame, vecs[i].nbits);
            chk_all($sformatf("vec%0d", i), LDAC ? vecs[i].vout_exp_ldac : vecs[i].vout_exp,
                    vecs[i].pd_exp, int'(vecs[i].fc_exp), int'(vecs[i].ec_exp));
        end
        exp_fc = 10;
        exp_ec = 2;
        exp_v  = 48'h7FF123456001;

        // 16th sclk fall coincides with sync_n rise: the sclk edge is dropped.
        frame_body(16'h1FFF, 15);
        dac_if.din = 1'b1;
        cyc(2);
        dac_if.sclk   = 1'b0;
        dac_if.sync_n = 1'b1;
        cyc(6);
        dac_if.sclk = 1'b1;
        cyc(4);
        exp_ec++;
        chk_all("edge_priority", exp_v, 4'b0000, exp_fc, exp_ec);

        // Exact latency: sync_n rise acted on at the 3rd mclk edge.
        send_frame(16'h0ABC, 16);
        exp_fc++;
        frame_body(16'h2000, 16);
        dac_if.sync_n = 1'b1;
        cyc(2);
        chk("latency.edge2", dac_if.vout, exp_v);
        cyc(1);
        exp_v = 48'h7FF123456ABC;
        chk("latency.edge3", dac_if.vout, exp_v);
        exp_fc++;
        cyc(4);
        chk("latency.frame_cnt", {40'd0, dac_if.frame_cnt}, 48'(exp_fc));

`ifdef DAC_LDAC_EN
        send_frame(16'h4555, 16);
        exp_fc++;
        chk("ldac.before", dac_if.vout, exp_v);
        dac_if.ldac_n = 1'b0;
        cyc(2);
        chk("ldac.edge2", dac_if.vout, exp_v);
        cyc(1);
        exp_v = 48'h7FF123555ABC;
        chk("ldac.edge3", dac_if.vout, exp_v);
        dac_if.ldac_n = 1'b1;
        cyc(4);
`endif

        // sclk activity with sync_n high must not start a frame.
        dac_if.din = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dac_if.sclk = 1'b0;
            cyc(4);
            dac_if.sclk = 1'b1;
            cyc(4);
            chk($sformatf("idle_sclk%0d.dbg_shift", i), {47'd0, dac_if.dbg_shift}, 48'd0);
        end
        chk_all("idle_sclk", exp_v, 4'b0000, exp_fc, exp_ec);

        // Empty frames drive err_cnt into saturation.
        for (int i = 0; i < 260; i++) begin
            dac_if.sync_n = 1'b0;
            cyc(4);
            dac_if.sync_n = 1'b1;
            cyc(4);
        end
        cyc(4);
        chk_all("err_saturate", exp_v, 4'b0000, exp_fc, 255);

        // Reset in the middle of a frame discards it without counting an error.
        dac_if.sync_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 5; i++) begin
            dac_if.sclk = 1'b0;
            cyc(4);
            dac_if.sclk = 1'b1;
            cyc(4);
        end
        rst = 1'b1;
        dac_if.sync_n = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        chk_all("mid_frame_reset", 48'd0, 4'b0000, 0, 0);
        chk("mid_frame_reset.dbg_shift", {47'd0, dac_if.dbg_shift}, 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
